// File: rtl/keccak_f_iter.sv
// Iterative Keccak-p[25*2**l, nr]: nr clocks from acceptance to out_valid; in_ready only in IDLE, result held until out_ready.
// Optional KECCAK_UNROLL2_EN chains two rounds per clock (nr must be even, latency nr/2).
module keccak_round #(
  parameter int l = 6
) (
  input  logic [25*(2**l)-1:0] state_i,
  input  logic [l:0]           rc_i,
  output logic [25*(2**l)-1:0] state_o
);
  localparam int W = 2**l;

  function automatic int rho_off(input int i);
    int t [25];
    t = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
          41, 45, 15, 21, 8, 18, 2, 61, 56, 14};
    return t[i] % W;
  endfunction

  function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int r);
    if (r == 0) return v;
    return (v << r) | (v >> (W - r));
  endfunction

  logic [W-1:0] a [25];
  logic [W-1:0] p [25];
  logic [W-1:0] c [5];
  logic [W-1:0] d [5];

  always_comb begin
    state_o = '0;
    p = '{default: '0};
    for (int i = 0; i < 25; i++) a[i] = state_i[W*i +: W];
    for (int x = 0; x < 5; x++) c[x] = a[x] ^ a[x+5] ^ a[x+10] ^ a[x+15] ^ a[x+20];
    for (int x = 0; x < 5; x++) d[x] = c[(x+4)%5] ^ rotl(c[(x+1)%5], 1 % W);
    // theta and rho fused, written straight into the pi destination lane
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        p[y + 5*((2*x + 3*y) % 5)] = rotl(a[x+5*y] ^ d[x], rho_off(x + 5*y));
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        state_o[W*(x+5*y) +: W] = p[x+5*y] ^ (~p[(x+1)%5 + 5*y] & p[(x+2)%5 + 5*y]);
    // compact rc bit j lands on lane bit 2**j-1
    for (int j = 0; j <= l; j++) state_o[(1<<j)-1] = state_o[(1<<j)-1] ^ rc_i[j];
  end
endmodule

module keccak_f_iter #(
  parameter int l  = 6,
  parameter int nr = 12 + 2*l
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [25*(2**l)-1:0] in_state,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [25*(2**l)-1:0] out_state,
  output logic                 busy,
  output logic [4:0]           round_idx
);
  localparam int w = 2**l;
  localparam int b = 25*w;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
`ifdef KECCAK_UNROLL2_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam logic [4:0] IR_FIRST = 5'(12 + 2*l - nr);
  localparam logic [4:0] IR_LAST  = 5'(12 + 2*l - STEP);
  localparam logic [4:0] IR_STEP  = 5'(STEP);

  function automatic logic [l:0] rc_lut(input logic [4:0] ir);
    logic [6:0] t;
    case (ir)
      5'd0:  t = 7'h01;  5'd1:  t = 7'h1A;  5'd2:  t = 7'h5E;  5'd3:  t = 7'h70;
      5'd4:  t = 7'h1F;  5'd5:  t = 7'h21;  5'd6:  t = 7'h79;  5'd7:  t = 7'h55;
      5'd8:  t = 7'h0E;  5'd9:  t = 7'h0C;  5'd10: t = 7'h35;  5'd11: t = 7'h26;
      5'd12: t = 7'h3F;  5'd13: t = 7'h4F;  5'd14: t = 7'h5D;  5'd15: t = 7'h53;
      5'd16: t = 7'h52;  5'd17: t = 7'h48;  5'd18: t = 7'h16;  5'd19: t = 7'h66;
      5'd20: t = 7'h79;  5'd21: t = 7'h58;  5'd22: t = 7'h21;  5'd23: t = 7'h74;
      default: t = 7'h00;
    endcase
    return (l+1)'(t);
  endfunction

  logic [1:0]   fsm_q, fsm_d;
  logic [4:0]   ir_q, ir_d;
  logic [b-1:0] st_q, st_d;
  logic [b-1:0] rnd0, rnd_out;
  logic [l:0]   rc_a;

  assign rc_a = rc_lut(ir_q);
  keccak_round #(.l(l)) u_round0 (.state_i(st_q), .rc_i(rc_a), .state_o(rnd0));

`ifdef KECCAK_UNROLL2_EN
  logic [l:0]   rc_b;
  logic [b-1:0] rnd1;
  assign rc_b = rc_lut(ir_q + 5'd1);
  keccak_round #(.l(l)) u_round1 (.state_i(rnd0), .rc_i(rc_b), .state_o(rnd1));
  assign rnd_out = rnd1;
  if (nr % 2 != 0) begin : g_odd_nr
    $error("keccak_f_iter: nr must be even when two rounds run per clock");
  end
`else
  assign rnd_out = rnd0;
`endif

  always_comb begin
    fsm_d = fsm_q;
    ir_d  = ir_q;
    st_d  = st_q;
    case (fsm_q)
      S_IDLE: if (in_valid) begin
        st_d  = in_state;
        ir_d  = IR_FIRST;
        fsm_d = S_RUN;
      end
      S_RUN: begin
        st_d = rnd_out;
        ir_d = ir_q + IR_STEP;
        // ir parks at 0 outside RUN so round_idx needs no extra gating
        if (ir_q == IR_LAST) begin
          ir_d  = '0;
          fsm_d = S_DONE;
        end
      end
      S_DONE: if (out_ready) fsm_d = S_IDLE;
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q <= S_IDLE;
      ir_q  <= '0;
      st_q  <= '0;
    end else begin
      fsm_q <= fsm_d;
      ir_q  <= ir_d;
      st_q  <= st_d;
    end
  end

  assign in_ready  = (fsm_q == S_IDLE);
  assign out_valid = (fsm_q == S_DONE);
  assign busy      = (fsm_q == S_RUN);
  assign round_idx = ir_q;
  assign out_state = st_q;
endmodule

// File: tb/tb_keccak_f_iter.sv
// Bench for keccak_f_iter: three instances (1600/24, 1600/12, 200/18) checked against a FIPS202-rule model.
`timescale 1ns/1ps
module tb_keccak_f_iter;
`ifdef KECCAK_UNROLL2_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic         a_iv, a_ir, a_ov, a_or, a_busy;
  logic [1599:0] a_is, a_os;
  logic [4:0]   a_idx;
  logic         r_iv, r_ir, r_ov, r_or, r_busy;
  logic [1599:0] r_is, r_os;
  logic [4:0]   r_idx;
  logic         s_iv, s_ir, s_ov, s_or, s_busy;
  logic [199:0] s_is, s_os;
  logic [4:0]   s_idx;

  keccak_f_iter #(.l(6), .nr(24)) u6 (
    .clk(clk), .reset(reset), .in_valid(a_iv), .in_ready(a_ir), .in_state(a_is),
    .out_valid(a_ov), .out_ready(a_or), .out_state(a_os), .busy(a_busy), .round_idx(a_idx));
  keccak_f_iter #(.l(6), .nr(12)) u6r (
    .clk(clk), .reset(reset), .in_valid(r_iv), .in_ready(r_ir), .in_state(r_is),
    .out_valid(r_ov), .out_ready(r_or), .out_state(r_os), .busy(r_busy), .round_idx(r_idx));
  keccak_f_iter #(.l(3), .nr(18)) u3 (
    .clk(clk), .reset(reset), .in_valid(s_iv), .in_ready(s_ir), .in_state(s_is),
    .out_valid(s_ov), .out_ready(s_or), .out_state(s_os), .busy(s_busy), .round_idx(s_idx));

  int n_chk = 0;
  int n_pass = 0;

  // ---------------- reference model ----------------
  function automatic bit rcf(input int t);
    logic [8:0] r;
    r = 9'd1;
    for (int i = 0; i < t % 255; i++) begin
      r = r << 1;
      if (r[8]) r = r ^ 9'h171;
    end
    return r[0];
  endfunction

  function automatic logic [6:0] rc7(input int ir, input int l);
    logic [6:0] r;
    r = '0;
    for (int j = 0; j <= l; j++) r[j] = rcf(j + 7*ir);
    return r;
  endfunction

  function automatic logic [63:0] rotw(input logic [63:0] v, input int r, input int w, input logic [63:0] m);
    int s;
    s = r % w;
    if (s == 0) return v & m;
    return ((v << s) | (v >> (w - s))) & m;
  endfunction

  function automatic logic [1599:0] kp(input logic [1599:0] s, input int l, input int nr);
    int w, x, y, nx;
    logic [63:0] m;
    logic [63:0] A [25];
    logic [63:0] B [25];
    logic [63:0] C [5];
    logic [63:0] D [5];
    int off [25];
    logic [1599:0] r, tmp;
    w = 1 << l;
    m = (l == 6) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    for (int i = 0; i < 25; i++) A[i] = 64'(s >> (w*i)) & m;
    off[0] = 0; x = 1; y = 0;
    for (int t = 0; t < 24; t++) begin
      off[x+5*y] = ((t+1)*(t+2)/2) % w;
      nx = y; y = (2*x + 3*y) % 5; x = nx;
    end
    for (int ir = 12+2*l-nr; ir < 12+2*l; ir++) begin
      for (int xi = 0; xi < 5; xi++) C[xi] = A[xi] ^ A[xi+5] ^ A[xi+10] ^ A[xi+15] ^ A[xi+20];
      for (int xi = 0; xi < 5; xi++) D[xi] = C[(xi+4)%5] ^ rotw(C[(xi+1)%5], 1, w, m);
      for (int i = 0; i < 25; i++) A[i] = A[i] ^ D[i%5];
      for (int xi = 0; xi < 5; xi++)
        for (int yi = 0; yi < 5; yi++)
          B[yi + 5*((2*xi + 3*yi) % 5)] = rotw(A[xi+5*yi], off[xi+5*yi], w, m);
      for (int xi = 0; xi < 5; xi++)
        for (int yi = 0; yi < 5; yi++)
          A[xi+5*yi] = B[xi+5*yi] ^ (~B[(xi+1)%5+5*yi] & B[(xi+2)%5+5*yi] & m);
      for (int j = 0; j <= l; j++)
        if (rcf(j + 7*ir)) A[0] = A[0] ^ (64'd1 << ((1<<j)-1));
    end
    r = '0;
    for (int i = 0; i < 25; i++) begin
      tmp = '0; tmp[63:0] = A[i];
      r = r | (tmp << (w*i));
    end
    return r;
  endfunction

  function automatic logic [1599:0] rnd1600();
    logic [1599:0] v;
    for (int i = 0; i < 50; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_st(input string tag, input logic [1599:0] obs, input logic [1599:0] exp);
    int k;
    k = 0;
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      for (int i = 24; i >= 0; i--) if (obs[64*i +: 64] !== exp[64*i +: 64]) k = i;
      $error("FAIL %s chunk%0d observed=%h expected=%h", tag, k, obs[64*k +: 64], exp[64*k +: 64]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1599:0] get_os(input int which);
    case (which)
      0: return a_os;
      1: return r_os;
      default: return {1400'd0, s_os};
    endcase
  endfunction

  function automatic logic [2:0] get_flags(input int which);
    case (which)
      0: return {a_ir, a_ov, a_busy};
      1: return {r_ir, r_ov, r_busy};
      default: return {s_ir, s_ov, s_busy};
    endcase
  endfunction

  function automatic logic [4:0] get_idx(input int which);
    case (which)
      0: return a_idx;
      1: return r_idx;
      default: return s_idx;
    endcase
  endfunction

  function automatic logic [6:0] get_rc(input int which);
    if (which == 0) return u6.rc_a;
    return u6r.rc_a;
  endfunction

  task automatic drive(input int which, input logic iv, input logic [1599:0] s);
    case (which)
      0: begin a_iv = iv; a_is = s; end
      1: begin r_iv = iv; r_is = s; end
      default: begin s_iv = iv; s_is = s[199:0]; end
    endcase
  endtask

  // One permutation: accept, track round_idx/rc per RUN cycle, check latency and result.
  task automatic perm(input int which, input logic [1599:0] s_in, input bit hold, input string tag);
    int l, nr, ir0, lat, k;
    logic [1599:0] s, exp;
    l   = (which == 2) ? 3 : 6;
    nr  = (which == 0) ? 24 : (which == 1) ? 12 : 18;
    ir0 = 12 + 2*l - nr;
    lat = nr / STEP;
    s   = (which == 2) ? {1400'd0, s_in[199:0]} : s_in;
    exp = kp(s, l, nr);
    drive(which, 1'b1, s);
    tick();
    drive(which, 1'b0, s);
    k = 0;
    while (!get_flags(which)[1] && k < 100) begin
      chk({tag, " idx"}, 64'(get_idx(which)), 64'(ir0 + STEP*k));
      if (which < 2) chk({tag, " rc"}, 64'(get_rc(which)), 64'(rc7(ir0 + STEP*k, 6)));
      tick();
      k++;
    end
    chk({tag, " latency"}, 64'(k), 64'(lat));
    chk_st({tag, " out"}, get_os(which), exp);
    if (!hold) begin
      tick();
      chk({tag, " idle"}, 64'(get_flags(which)), 64'(3'b100));
    end
  endtask

  logic [1599:0] v, exp_hold;

  initial begin
    reset = 1'b1;
    a_iv = 0; a_is = '0; a_or = 1;
    r_iv = 0; r_is = '0; r_or = 1;
    s_iv = 0; s_is = '0; s_or = 1;
    tick(); tick();
    chk("reset flags", 64'(get_flags(0)), 64'(3'b100));
    chk("reset idx", 64'(a_idx), 64'd0);
    chk_st("reset out", a_os, '0);
    reset = 1'b0;

    // zero state, full 24 rounds, against the published Keccak-f[1600] vector
    perm(0, '0, 1'b0, "f1600 zero");
    chk("f1600 lane00", a_os[63:0], 64'hF125_8F79_40E1_DDE7);
    chk("f1600 lane10", a_os[127:64], 64'h84D5_CCF9_33C0_478A);

    // backpressure: result held in DONE, inputs ignored
    a_or = 1'b0;
    v = rnd1600();
    exp_hold = kp(v, 6, 24);
    perm(0, v, 1'b1, "bp run");
    a_iv = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a_is = rnd1600();
      tick();
      chk("bp flags", 64'(get_flags(0)), 64'(3'b010));
      chk_st("bp hold", a_os, exp_hold);
    end
    a_iv = 1'b0;
    a_or = 1'b1;
    tick();
    chk("bp release", 64'(get_flags(0)), 64'(3'b100));
    chk_st("bp after", a_os, exp_hold);
    perm(0, rnd1600(), 1'b0, "f1600 rand");

    // reduced rounds
    perm(1, '0, 1'b0, "p12 zero");
    perm(1, rnd1600(), 1'b0, "p12 rand");

    // abort in the 5th RUN cycle
    a_is = rnd1600();
    a_iv = 1'b1;
    tick();
    a_iv = 1'b0;
    a_is = '0;
    repeat (4) tick();
    chk("abort busy", 64'(a_busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort flags", 64'(get_flags(0)), 64'(3'b100));
    chk("abort idx", 64'(a_idx), 64'd0);
    chk_st("abort out", a_os, '0);
    perm(0, '0, 1'b0, "post abort");
    chk("post abort lane00", a_os[63:0], 64'hF125_8F79_40E1_DDE7);

    // small width, out_ready held high
    perm(2, '0, 1'b0, "f200 zero");
    perm(2, rnd1600(), 1'b0, "f200 rand0");
    perm(2, rnd1600(), 1'b0, "f200 rand1");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
